// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter: default widths and the
// grant encoding used by the RAM command stage and the read-data tag pipeline.
package vga_fb_arbiter_pkg;

    localparam int ADDR_W_DEF     = 15;
    localparam int DATA_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_HRD  = 2'd2,
        GNT_HWR  = 2'd3
    } gnt_e;

    // Fixed priority: display fetch, then a pending host read, then the
    // write FIFO head. A pending read outranks the drain so a write accepted
    // after the read cannot overtake it.
    function automatic gnt_e pick_grant(input logic disp_req,
                                        input logic rd_pend,
                                        input logic fifo_empty);
        if (disp_req) begin
            return GNT_DISP;
        end else if (rd_pend) begin
            return GNT_HRD;
        end else if (!fifo_empty) begin
            return GNT_HWR;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display, host and RAM buses of the framebuffer arbiter. Signal suffixes
// are from the arbiter's point of view (slave modport).
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              disp_req_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic              disp_valid_o;
    logic [DATA_W-1:0] disp_data_o;

    logic              host_valid_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_ready_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;

    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  disp_req_i, disp_addr_i,
        output disp_valid_o, disp_data_o,
        input  host_valid_i, host_we_i, host_addr_i, host_wdata_i,
        output host_ready_o, host_rvalid_o, host_rdata_o,
        output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output disp_req_i, disp_addr_i,
        input  disp_valid_o, disp_data_o,
        output host_valid_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_ready_o, host_rvalid_o, host_rdata_o,
        input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );

endinterface

// File: rtl/vga_fb_arbiter_fb_wr_fifo.sv
// Host write FIFO (fb_wr_fifo): holds {addr, data} until an idle RAM cycle.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vga_fb_arbiter_fb_wr_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    // Pointer advance; push and pop in the same cycle leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless once the pointers are flushed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display fetch always wins, host reads wait for
// the write FIFO to drain, host writes are buffered and drained into idle
// cycles. RAM commands are registered; a two-stage grant tag routes the
// RAM read data back to its owner two cycles after the grant.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    vga_fb_arbiter_if.slave bus
);
    localparam int FIFO_W = ADDR_W + DATA_W;

    logic              fifo_full, fifo_empty;
    logic [FIFO_W-1:0] fifo_dout;
    logic              host_ready;
    logic              wr_acc, rd_acc;
    gnt_e              gnt;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    gnt_e              tag1_q, tag1_d;
    gnt_e              tag2_q, tag2_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    // Reads are only taken when nothing older can still touch the RAM.
    assign host_ready = rst_i && (bus.host_we_i ? !fifo_full
                                  : (fifo_empty && !rd_pend_q && !rd_inflight_q));
    assign wr_acc = bus.host_valid_i && host_ready && bus.host_we_i;
    assign rd_acc = bus.host_valid_i && host_ready && !bus.host_we_i;
    assign gnt    = pick_grant(bus.disp_req_i, rd_pend_q, fifo_empty);

    vga_fb_arbiter_fb_wr_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_acc),
        .din_i   ({bus.host_addr_i, bus.host_wdata_i}),
        .pop_i   (gnt == GNT_HWR),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next RAM command from this cycle's grant; idle cycles drive all zeros.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        case (gnt)
            GNT_DISP: begin
                ram_en_d   = 1'b1;
                ram_addr_d = bus.disp_addr_i;
            end
            GNT_HRD: begin
                ram_en_d   = 1'b1;
                ram_addr_d = rd_addr_q;
            end
            GNT_HWR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = fifo_dout[FIFO_W-1 -: ADDR_W];
                ram_wdata_d = fifo_dout[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    // Host read bookkeeping and the owner tag pipeline.
    always_comb begin
        tag1_d    = gnt;
        tag2_d    = tag1_q;
        rd_addr_d = rd_acc ? bus.host_addr_i : rd_addr_q;

        rd_pend_d = rd_pend_q;
        if (rd_acc)              rd_pend_d = 1'b1;
        else if (gnt == GNT_HRD) rd_pend_d = 1'b0;

        // Held from the cycle after issue through the data-return cycle.
        rd_inflight_d = rd_inflight_q;
        if (gnt == GNT_HRD)         rd_inflight_d = 1'b1;
        else if (tag2_q == GNT_HRD) rd_inflight_d = 1'b0;
    end

    // State registers; reset drops pending and in-flight reads with their tags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            tag1_q        <= GNT_NONE;
            tag2_q        <= GNT_NONE;
            rd_pend_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            rd_pend_q     <= rd_pend_d;
            rd_inflight_q <= rd_inflight_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign bus.host_ready_o  = host_ready;
    assign bus.ram_en_o      = ram_en_q;
    assign bus.ram_we_o      = ram_we_q;
    assign bus.ram_addr_o    = ram_addr_q;
    assign bus.ram_wdata_o   = ram_wdata_q;
    // Valids come straight from the tag register; data is the RAM output,
    // gated so nothing leaks out while its owner is not selected.
    assign bus.disp_valid_o  = (tag2_q == GNT_DISP);
    assign bus.disp_data_o   = (tag2_q == GNT_DISP) ? bus.ram_rdata_i : '0;
    assign bus.host_rvalid_o = (tag2_q == GNT_HRD);
    assign bus.host_rdata_o  = (tag2_q == GNT_HRD) ? bus.ram_rdata_i : '0;

endmodule
